aemb2_opmx_mt: RTL
==================

Name: aemb2_opmx_mt

Overview:
Parametrised operand fetch mux for the multi-threaded AEMB2 pipeline. It sits between the register file and the EX stage, and registers the four operands OPA, OPB, OPM and OPX once per enabled cycle. Over the two-thread, single-forward version it adds:
- N hardware threads, each with its own IMM-prefix latch;
- a two-level forward network (EX and MA), matched per thread;
- load-use hazard detection, which inserts a bubble and asserts a stall.

Parameters:
DW, 32, operand datapath width; must be at least 32. Immediates sign-extend from bit 31 of the combined 32-bit immediate.
TIDW, 1, thread-ID width; THREADS = 2**TIDW (1 to 8).
FWD_MA, 1, 1 enables the MA-stage forward path; 0 removes it (only the EX path and the register file are used).

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
ena_i  in  1  pipeline enable; 0 freezes all state
tid_i  in  TIDW  thread of the instruction in IF
opc_i  in  6  opcode
imm_i  in  16  immediate field
pc_i  in  DW-2  PC of the instruction, bits [DW-1:2]
rd_i, ra_i, rb_i  in  5 each  register specifiers
regd_i, rega_i, regb_i  in  DW each  register-file read data
skp_i  in  1  branch without delay slot is taken; the IF instruction is killed
ex_rd_i  in  5  EX destination register
ex_tid_i  in  TIDW  EX thread
ex_alu_i  in  1  EX result is an ALU result that can be forwarded
ex_lod_i  in  1  EX instruction is a load (result not yet available)
ex_res_i  in  DW  EX result
ma_rd_i  in  5  MA destination register
ma_tid_i  in  TIDW  MA thread
ma_vld_i  in  1  MA result is valid for forwarding
ma_res_i  in  DW  MA result
opa_o, opb_o, opm_o, opx_o  out  DW each  registered operands
vld_o  out  1  registered; operands are valid (0 means bubble)
stall_o  out  1  combinational load-use stall request to IF
imm_pend_o  out  THREADS  registered; per-thread "IMM prefix pending" flags

Behaviour:
- Reset (asynchronous): all outputs, all IMM latches and all pending flags clear to 0.
- ena_i=0: every register holds its value. stall_o is still evaluated combinationally.
- Decode:
  - IMM = 6'o54.
  - BRU = 6'o46 or 6'o56; BCC = 6'o47 or 6'o57.
  - MOV = 6'o45.
  - STR: {opc[5:4],opc[2]} = 3'o7.
  - Immediate form: opc[3] = 1.
- IMM prefix, per thread t: on an enabled, non-stalled cycle with tid_i=t:
  - imm_pend[t] <= IMM & !skp_i;
  - imm_hi[t] <= imm_i.
  - Other threads' latches are untouched.
- Sign-extended immediate (SIMM):
  - Low 16 bits = imm_i.
  - High 16 bits = imm_hi[tid_i] if imm_pend[tid_i], else 16 copies of imm_i[15].
  - Then sign-extend to DW.
- Forward match for source register s: s != 0 and the producing stage's thread equals tid_i.
  - EX hit: ex_rd_i == s, ex_tid_i == tid_i, ex_alu_i = 1.
  - MA hit: ma_rd_i == s, ma_tid_i == tid_i, ma_vld_i = 1, FWD_MA = 1.
  - Priority: EX over MA over register file.
- Operand selection:
  - OPA: {pc_i,2'b00} for BRU, BCC or MOV; otherwise forward or rega_i.
  - OPB: SIMM when opc[3]=1; otherwise forward or regb_i (specifier rb_i).
  - OPX: forward or rega_i for BCC; 0 otherwise.
  - OPM: forward or regd_i for STR (specifier rd_i); 0 otherwise.
- Load-use stall: stall_o = ex_lod_i & (ex_tid_i == tid_i) & (ex_rd_i != 0), AND ex_rd_i matches at least one source actually used:
  - ra_i when OPA is not the PC, or when BCC;
  - rb_i when opc[3]=0;
  - rd_i when STR.
- On a stalled enabled cycle:
  - vld_o <= 0;
  - operand registers and IMM state hold;
  - IF re-presents the same instruction on the next cycle.
- Non-stalled enabled cycle: operands load and vld_o <= 1. Latency is one cycle from IF inputs to outputs.
- skp_i=1: vld_o <= 0 and the thread's imm_pend clears. A killed IMM never survives.
- Simultaneous EX and MA hit on the same register: EX wins.
- A hit from a different thread: ignored.
- imm_pend applies only to the next instruction of that same thread. Interleaving other threads does not consume it.
- Reset mid-stall: everything clears immediately; no pending IMM survives.

Test Plan:
- Reset is asserted asynchronously mid-cycle -> all outputs and imm_pend_o go to 0 before the next edge.
- T0: IMM 16'h1234, then ADDI imm 16'h8000. T1 executes ADDI imm 16'hFFFF between the two -> T1 opb_o=32'hFFFFFFFF; T0 opb_o=32'h12348000.
- EX (tid 0, rd 5, res 32'hAAAA0000) and MA (tid 0, rd 5, res 32'h5555) both match ra=5 -> opa_o=32'hAAAA0000. With ex_tid_i=1 instead -> opa_o=32'h5555.
- ra=0 while ex_rd_i=0 and ex_alu_i=1 -> opa_o=rega_i; no forward from r0.
- Load in EX to r7 (same thread); IF is ADD rb=7 -> stall_o=1, vld_o=0 for one cycle. Next cycle (MA forward of r7=32'h77) -> opb_o=32'h77, vld_o=1.
- IMM followed by skp_i=1 -> imm_pend_o[tid]=0, and the next immediate sign-extends normally.

Source files
------------

// File: rtl/aemb2_opmx_mt.sv
// Operand fetch mux for the multi-threaded AEMB2 pipeline: per-thread IMM prefix,
// EX/MA forwarding matched per thread, and load-use stall with bubble insertion.
module aemb2_opmx_mt #(
    parameter int unsigned DW     = 32,
    parameter int unsigned TIDW   = 1,
    parameter int unsigned FWD_MA = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   ena_i,
    input  logic [TIDW-1:0]        tid_i,
    input  logic [5:0]             opc_i,
    input  logic [15:0]            imm_i,
    input  logic [DW-3:0]          pc_i,
    input  logic [4:0]             rd_i,
    input  logic [4:0]             ra_i,
    input  logic [4:0]             rb_i,
    input  logic [DW-1:0]          regd_i,
    input  logic [DW-1:0]          rega_i,
    input  logic [DW-1:0]          regb_i,
    input  logic                   skp_i,
    input  logic [4:0]             ex_rd_i,
    input  logic [TIDW-1:0]        ex_tid_i,
    input  logic                   ex_alu_i,
    input  logic                   ex_lod_i,
    input  logic [DW-1:0]          ex_res_i,
    input  logic [4:0]             ma_rd_i,
    input  logic [TIDW-1:0]        ma_tid_i,
    input  logic                   ma_vld_i,
    input  logic [DW-1:0]          ma_res_i,
    output logic [DW-1:0]          opa_o,
    output logic [DW-1:0]          opb_o,
    output logic [DW-1:0]          opm_o,
    output logic [DW-1:0]          opx_o,
    output logic                   vld_o,
    output logic                   stall_o,
    output logic [(1<<TIDW)-1:0]   imm_pend_o
);

    localparam int unsigned THREADS = 1 << TIDW;

    localparam logic [5:0] OP_IMM  = 6'o54;
    localparam logic [5:0] OP_BRU0 = 6'o46;
    localparam logic [5:0] OP_BRU1 = 6'o56;
    localparam logic [5:0] OP_BCC0 = 6'o47;
    localparam logic [5:0] OP_BCC1 = 6'o57;
    localparam logic [5:0] OP_MOV  = 6'o45;

    logic [THREADS-1:0]       immPend;
    logic [THREADS-1:0][15:0] immHi;

    logic isImm, isBru, isBcc, isMov, isStr, isPcOp;
    logic useA, useB, useD;
    logic signed [31:0] simm32;
    logic [DW-1:0] simm;
    logic [DW-1:0] fwdA, fwdB, fwdD;
    logic [DW-1:0] opaNxt, opbNxt, opmNxt, opxNxt;

    assign imm_pend_o = immPend;

    // EX beats MA beats register file; r0 and other threads never forward
    function automatic logic [DW-1:0] fwdSel(input logic [4:0] s, input logic [DW-1:0] rf);
        logic exHit, maHit;
        exHit = (s != 5'd0) && ex_alu_i && (ex_tid_i == tid_i) && (ex_rd_i == s);
        maHit = (FWD_MA != 0) && (s != 5'd0) && ma_vld_i && (ma_tid_i == tid_i) && (ma_rd_i == s);
        if (exHit)      return ex_res_i;
        else if (maHit) return ma_res_i;
        else            return rf;
    endfunction

    always_comb begin
        isImm  = (opc_i == OP_IMM);
        isBru  = (opc_i == OP_BRU0) || (opc_i == OP_BRU1);
        isBcc  = (opc_i == OP_BCC0) || (opc_i == OP_BCC1);
        isMov  = (opc_i == OP_MOV);
        isStr  = ({opc_i[5:4], opc_i[2]} == 3'o7);
        isPcOp = isBru || isBcc || isMov;

        simm32 = {(immPend[tid_i] ? immHi[tid_i] : {16{imm_i[15]}}), imm_i};
        simm   = DW'(simm32);

        fwdA = fwdSel(ra_i, rega_i);
        fwdB = fwdSel(rb_i, regb_i);
        fwdD = fwdSel(rd_i, regd_i);

        opaNxt = isPcOp ? {pc_i, 2'b00} : fwdA;
        opbNxt = opc_i[3] ? simm : fwdB;
        opxNxt = isBcc ? fwdA : '0;
        opmNxt = isStr ? fwdD : '0;

        // Only sources the instruction really reads can trigger a load-use stall
        useA = !isPcOp || isBcc;
        useB = !opc_i[3];
        useD = isStr;
        stall_o = ex_lod_i && (ex_tid_i == tid_i) && (ex_rd_i != 5'd0) &&
                  ((useA && (ex_rd_i == ra_i)) ||
                   (useB && (ex_rd_i == rb_i)) ||
                   (useD && (ex_rd_i == rd_i)));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            opa_o   <= '0;
            opb_o   <= '0;
            opm_o   <= '0;
            opx_o   <= '0;
            vld_o   <= 1'b0;
            immPend <= '0;
            immHi   <= '0;
        end else if (ena_i) begin
            if (!stall_o) begin
                opa_o         <= opaNxt;
                opb_o         <= opbNxt;
                opm_o         <= opmNxt;
                opx_o         <= opxNxt;
                immHi[tid_i]  <= imm_i;
            end
            vld_o <= !stall_o && !skp_i;
            // A killed instruction leaves no pending prefix behind
            if (skp_i)
                immPend[tid_i] <= 1'b0;
            else if (!stall_o)
                immPend[tid_i] <= isImm;
        end
    end

endmodule
